// File: rtl/ext_pkg.sv
// Shared definitions for the sign-extension arbiter: requester IDs, common
// field descriptors, the extension mask and the output-stage state encoding.
package ext_pkg;

  localparam logic REQ_BRANCH = 1'b0;
  localparam logic REQ_DECODE = 1'b1;

  typedef struct packed {
    logic [3:0] msb;
    logic       shift;
  } ext_field_t;

  localparam ext_field_t BRANCH_OFF = '{msb: 4'd12, shift: 1'b1};
  localparam ext_field_t LDR_OFF    = '{msb: 4'd6,  shift: 1'b0};

  localparam logic [15:0] EXT_MASK = 16'hFFFF;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/ext_core.sv
// Combinational sign-extension: optional left shift by one, then extend from
// a selectable sign-bit position. Bits below the sign bit are left untouched.
module ext_core
  import ext_pkg::*;
(
  input  logic [15:0] word_i,
  input  logic [3:0]  msb_i,
  input  logic        shift_i,
  output logic [15:0] data_o
);

  logic [15:0] shifted;

  always_comb begin
    shifted = shift_i ? {word_i[14:0], 1'b0} : word_i;
    data_o  = shifted[msb_i] ? (shifted | (EXT_MASK << msb_i)) : shifted;
  end

endmodule

// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one ext_core between two requesters, with a
// single-entry valid/ready output stage. Contention counter under EXT_ARB_STATS_EN.
//
// state    | meaning
// ST_EMPTY | no result held, out_valid=0, a winner may load
// ST_FULL  | result held; loads again only when out_ready drains it this cycle
module ext_arbiter
  import ext_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIRST_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_word,
  input  logic [3:0]        req0_msb,
  input  logic              req0_shift,
  input  logic [DATA_W-1:0] req1_word,
  input  logic [3:0]        req1_msb,
  input  logic              req1_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  output logic [15:0]       stall_count
);

  localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  out_state_e  state_q;
  logic [15:0] data_q;
  logic        id_q;
  logic        last_grant_q;

  logic        can_load;
  logic        any_req;
  logic        gnt;
  logic        xfer;
  logic [15:0] op_word;
  logic [3:0]  op_msb;
  logic        op_shift;
  logic [15:0] ext_data;

  always_comb begin
    can_load = (state_q == ST_EMPTY) || out_ready;
    any_req  = |req_valid;
    // With both requesting, the one not served last wins; otherwise the lone requester.
    gnt      = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    xfer     = any_req && can_load && !rst;
    req_ready = 2'b00;
    if (xfer) req_ready = gnt ? 2'b10 : 2'b01;
    op_word  = gnt ? req1_word  : req0_word;
    op_msb   = gnt ? req1_msb   : req0_msb;
    op_shift = gnt ? req1_shift : req0_shift;
  end

  ext_core u_ext_core (
    .word_i  (op_word),
    .msb_i   (op_msb),
    .shift_i (op_shift),
    .data_o  (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      id_q         <= 1'b0;
      last_grant_q <= LAST_RST;
    end else if (xfer) begin
      state_q      <= ST_FULL;
      data_q       <= ext_data;
      id_q         <= gnt;
      last_grant_q <= gnt;
    end else if (out_ready) begin
      state_q      <= ST_EMPTY;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

`ifdef EXT_ARB_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] stall_d;
  logic        stall_inc;

  always_comb begin
    stall_inc = (req_valid == 2'b11) || (any_req && !can_load);
    stall_d   = stall_q;
    if (stall_inc && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_ext_arbiter.sv
// Directed bench for ext_arbiter: extension cases, round-robin, backpressure,
// async reset and idle drain, with hand-computed expected values.
module tb_ext_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req0_word;
  logic [3:0]  req0_msb;
  logic        req0_shift;
  logic [15:0] req1_word;
  logic [3:0]  req1_msb;
  logic        req1_shift;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_id;
  logic [15:0] stall_count;

  int n_tests;
  int n_fail;

`ifdef EXT_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  ext_arbiter #(.DATA_W(16), .FIRST_PRIO(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_word   (req0_word),
    .req0_msb    (req0_msb),
    .req0_shift  (req0_shift),
    .req1_word   (req1_word),
    .req1_msb    (req1_msb),
    .req1_shift  (req1_shift),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_stall(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req_valid  = 2'b00;
    req0_word  = 16'h0000;
    req0_msb   = 4'd0;
    req0_shift = 1'b0;
    req1_word  = 16'h0000;
    req1_msb   = 4'd0;
    req1_shift = 1'b0;
    out_ready  = 1'b1;
    #12;
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_data",  out_data, 16'h0000);
    chk("rst_id",    16'(out_id), 16'd0);
    chk("rst_ready", 16'(req_ready), 16'd0);
    chk("rst_stall", stall_count, 16'd0);
    step();
    rst = 1'b0;

    // single requester 0
    req_valid = 2'b01; req0_word = 16'h0080; req0_msb = 4'd7; req0_shift = 1'b0;
    #1;
    chk("r0_ready", 16'(req_ready), 16'd1);
    step();
    chk("r0_valid", 16'(out_valid), 16'd1);
    chk("r0_data",  out_data, 16'hFF80);
    chk("r0_id",    16'(out_id), 16'd0);
    req0_word = 16'h007F;
    step();
    chk("r0_pos",   out_data, 16'h007F);

    // idle drain
    req_valid = 2'b00;
    step();
    chk("drain_valid", 16'(out_valid), 16'd0);
    chk("drain_data",  out_data, 16'h007F);

    // requester 1 shift path
    req_valid = 2'b10; req1_word = 16'h0200; req1_msb = 4'd10; req1_shift = 1'b1;
    step();
    chk("r1_data", out_data, 16'hFC00);
    chk("r1_id",   16'(out_id), 16'd1);
    req1_word = 16'h8001; req1_msb = 4'd15;
    step();
    chk("r1_msb15", out_data, 16'h0002);
    req_valid = 2'b00;
    step();

    // fresh reset so contention starts from FIRST_PRIO with counter at zero
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req0_word = 16'h0001; req0_msb = 4'd15; req0_shift = 1'b0;
    req1_word = 16'h0002; req1_msb = 4'd15; req1_shift = 1'b0;
    req_valid = 2'b11;
    step();
    chk("cont_id0", 16'(out_id), 16'd0);
    chk("cont_d0",  out_data, 16'h0001);
    step();
    chk("cont_id1", 16'(out_id), 16'd1);
    chk("cont_d1",  out_data, 16'h0002);
    step();
    chk("cont_id2", 16'(out_id), 16'd0);
    step();
    chk("cont_id3", 16'(out_id), 16'd1);
    chk("cont_stall", stall_count, exp_stall(4));

    // backpressure: FULL holding id 1, both valid, consumer stalled
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 16'(req_ready), 16'd0);
      step();
      chk("bp_valid", 16'(out_valid), 16'd1);
      chk("bp_data",  out_data, 16'h0002);
      chk("bp_id",    16'(out_id), 16'd1);
    end
    chk("bp_stall", stall_count, exp_stall(7));
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 16'(req_ready), 16'd1);
    step();
    chk("bp_rel_valid", 16'(out_valid), 16'd1);
    chk("bp_rel_id",    16'(out_id), 16'd0);
    chk("bp_rel_data",  out_data, 16'h0001);
    chk("bp_rel_stall", stall_count, exp_stall(8));
    req_valid = 2'b00;

    // async reset mid-cycle while FULL
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 16'(out_valid), 16'd0);
    chk("arst_data",  out_data, 16'h0000);
    chk("arst_stall", stall_count, 16'd0);
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("arst_ready", 16'(req_ready), 16'd1);
    step();
    chk("arst_id",    16'(out_id), 16'd0);
    chk("arst_v",     16'(out_valid), 16'd1);
    req_valid = 2'b00;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
